// File: rtl/gate_pkg.sv
// Shared gate definitions: state encoding and sprite size used by the gate
// controller, draw and collision blocks.
package gate_pkg;

    typedef enum logic [2:0] {
        GATE_IDLE    = 3'd0,
        GATE_CLOSED  = 3'd1,
        GATE_OPENING = 3'd2,
        GATE_OPEN    = 3'd3,
        GATE_CLOSING = 3'd4
    } gate_state_t;

    localparam int GATE_SIZE = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_dwell_timer.sv
// Saturating frame counter for gate dwell times: synchronous clear, increment
// strobe and a terminal-count flag against a run-time limit.
module gate_dwell_timer #(
    parameter int WIDTH = 7
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             clear,
    input  logic             incr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (incr && (count_reg != MAX_COUNT)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count    = count_reg;
    assign at_limit = (count_reg == limit);

endmodule

// File: rtl/gate_a_ctrl.sv
// Frame-synchronous sequencer sliding the 9x9 gate between closed and open Y.
// Define GATE_A_BLINK_EN to blink the sprite during the warning window.
module gate_a_ctrl
    import gate_pkg::*;
#(
    parameter int START_X       = 300,
    parameter int CLOSED_Y      = 200,
    parameter int TRAVEL        = 18,
    parameter int STEP          = 2,
    parameter int OPEN_FRAMES   = 120,
    parameter int CLOSED_FRAMES = 90,
    parameter int WARN_FRAMES   = 30
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        trigger,
    input  logic        collision,
    output logic [10:0] ObjectStartX,
    output logic [10:0] ObjectStartY,
    output logic        gate_open,
    output logic        gate_warn,
    output logic        gate_visible,
    output logic [2:0]  gate_state
);

    localparam int CW = $clog2(max_int(OPEN_FRAMES, CLOSED_FRAMES) + 1);

    localparam logic [CW-1:0]       OPEN_LIM   = CW'(OPEN_FRAMES - 1);
    localparam logic [CW-1:0]       CLOSED_LIM = CW'(CLOSED_FRAMES - 1);
    localparam logic [CW-1:0]       WARN_START = CW'(OPEN_FRAMES - WARN_FRAMES);
    localparam logic [CW-1:0]       CNT_MAX    = '1;
    localparam logic signed [11:0]  OPEN_Y_S   = 12'(CLOSED_Y - TRAVEL);
    localparam logic signed [11:0]  CLOSED_Y_S = 12'(CLOSED_Y);
    localparam logic signed [11:0]  STEP_S     = 12'(STEP);
    localparam logic [10:0]         OPEN_Y_U   = 11'(CLOSED_Y - TRAVEL);
    localparam logic [10:0]         CLOSED_Y_U = 11'(CLOSED_Y);
    localparam logic [10:0]         START_X_U  = 11'(START_X);

    gate_state_t       state_reg, state_next;
    logic [10:0]       y_reg, y_next;
    logic [10:0]       x_reg;
    logic              open_reg, warn_reg, warn_next, vis_reg, vis_next;
    logic signed [11:0] y_dn, y_up;

    logic              dwell_clear, dwell_incr, dwell_done;
    logic [CW-1:0]     dwell_limit, dwell_count, cnt_after;

    gate_dwell_timer #(
        .WIDTH (CW)
    ) u_dwell (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .clear    (dwell_clear),
        .incr     (dwell_incr),
        .limit    (dwell_limit),
        .count    (dwell_count),
        .at_limit (dwell_done)
    );

    assign dwell_limit = (state_reg == GATE_OPEN) ? OPEN_LIM : CLOSED_LIM;

    // Y math is done signed and clamped before write-back so odd TRAVEL/STEP
    // ratios never overshoot either end.
    assign y_dn = $signed({1'b0, y_reg}) - STEP_S;
    assign y_up = $signed({1'b0, y_reg}) + STEP_S;

    always_comb begin
        state_next  = state_reg;
        y_next      = y_reg;
        dwell_clear = 1'b0;
        dwell_incr  = 1'b0;
        if (startOfFrame) begin
            if (!enable) begin
                state_next  = GATE_IDLE;
                y_next      = CLOSED_Y_U;
                dwell_clear = 1'b1;
            end else begin
                case (state_reg)
                    GATE_IDLE: begin
                        state_next  = GATE_CLOSED;
                        dwell_clear = 1'b1;
                    end
                    GATE_CLOSED: begin
                        if (trigger || dwell_done) state_next = GATE_OPENING;
                        else                       dwell_incr = 1'b1;
                    end
                    GATE_OPENING: begin
                        if (y_dn <= OPEN_Y_S) begin
                            y_next      = OPEN_Y_U;
                            state_next  = GATE_OPEN;
                            dwell_clear = 1'b1;
                        end else begin
                            y_next = y_dn[10:0];
                        end
                    end
                    GATE_OPEN: begin
                        if (dwell_done) state_next = GATE_CLOSING;
                        else            dwell_incr = 1'b1;
                    end
                    GATE_CLOSING: begin
                        if (collision) begin
                            state_next = GATE_OPENING;
                        end else if (y_up >= CLOSED_Y_S) begin
                            y_next      = CLOSED_Y_U;
                            state_next  = GATE_CLOSED;
                            dwell_clear = 1'b1;
                        end else begin
                            y_next = y_up[10:0];
                        end
                    end
                    default: begin
                        state_next  = GATE_IDLE;
                        y_next      = CLOSED_Y_U;
                        dwell_clear = 1'b1;
                    end
                endcase
            end
        end
    end

    // Counter value after this edge, so warn lines up with the registered state.
    always_comb begin
        if (dwell_clear)                           cnt_after = '0;
        else if (dwell_incr && dwell_count != CNT_MAX) cnt_after = dwell_count + CW'(1);
        else                                       cnt_after = dwell_count;
        warn_next = (state_next == GATE_OPEN) && (cnt_after >= WARN_START);
    end

`ifdef GATE_A_BLINK_EN
    logic [3:0] blink_reg, blink_next;

    always_comb begin
        blink_next = blink_reg;
        if (startOfFrame) begin
            if (warn_next) blink_next = warn_reg ? blink_reg + 4'd1 : 4'd0;
            else           blink_next = 4'd0;
        end
        vis_next = warn_next ? ~blink_next[3] : 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) blink_reg <= 4'd0;
        else         blink_reg <= blink_next;
    end
`else
    assign vis_next = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= GATE_IDLE;
            y_reg     <= CLOSED_Y_U;
            x_reg     <= START_X_U;
            open_reg  <= 1'b0;
            warn_reg  <= 1'b0;
            vis_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            x_reg     <= START_X_U;
            open_reg  <= (state_next == GATE_OPEN);
            warn_reg  <= warn_next;
            vis_reg   <= vis_next;
        end
    end

    assign ObjectStartX = x_reg;
    assign ObjectStartY = y_reg;
    assign gate_open    = open_reg;
    assign gate_warn    = warn_reg;
    assign gate_visible = vis_reg;
    assign gate_state   = state_reg;

endmodule

// File: tb/tb_gate_a_ctrl.sv
// Randomized scoreboard bench for gate_a_ctrl against a frame-level reference model.
module tb_gate_a_ctrl;

    localparam int START_X       = 300;
    localparam int CLOSED_Y      = 200;
    localparam int TRAVEL        = 18;
    localparam int STEP          = 2;
    localparam int OPEN_FRAMES   = 120;
    localparam int CLOSED_FRAMES = 90;
    localparam int WARN_FRAMES   = 30;
    localparam int OPEN_Y        = CLOSED_Y - TRAVEL;

    localparam int S_IDLE = 0, S_CLOSED = 1, S_OPENING = 2, S_OPEN = 3, S_CLOSING = 4;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;
    logic        trigger = 1'b0;
    logic        collision = 1'b0;
    logic [10:0] ObjectStartX, ObjectStartY;
    logic        gate_open, gate_warn, gate_visible;
    logic [2:0]  gate_state;

    gate_a_ctrl #(
        .START_X       (START_X),
        .CLOSED_Y      (CLOSED_Y),
        .TRAVEL        (TRAVEL),
        .STEP          (STEP),
        .OPEN_FRAMES   (OPEN_FRAMES),
        .CLOSED_FRAMES (CLOSED_FRAMES),
        .WARN_FRAMES   (WARN_FRAMES)
    ) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .trigger      (trigger),
        .collision    (collision),
        .ObjectStartX (ObjectStartX),
        .ObjectStartY (ObjectStartY),
        .gate_open    (gate_open),
        .gate_warn    (gate_warn),
        .gate_visible (gate_visible),
        .gate_state   (gate_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int y;
        int st;
        int open;
        int warn;
        int vis;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    logic sof_seen = 1'b0;

    // Reference model state, advanced once per frame pulse.
    int m_st, m_y, m_cnt, m_warn_run;
    bit m_warn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e, input string tag);
        check({tag, "_x"},     32'(ObjectStartX), 32'(START_X));
        check({tag, "_y"},     32'(ObjectStartY), 32'(e.y));
        check({tag, "_state"}, 32'(gate_state),   32'(e.st));
        check({tag, "_open"},  32'(gate_open),    32'(e.open));
        check({tag, "_warn"},  32'(gate_warn),    32'(e.warn));
        check({tag, "_vis"},   32'(gate_visible), 32'(e.vis));
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.y = CLOSED_Y; e.st = S_IDLE; e.open = 0; e.warn = 0; e.vis = 1;
        return e;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_y = CLOSED_Y; m_cnt = 0; m_warn_run = 0; m_warn = 1'b0;
    endtask

    task automatic model_frame(input bit en, input bit trig, input bit col);
        bit was_warn;
        was_warn = m_warn;
        if (!en) begin
            m_st = S_IDLE; m_y = CLOSED_Y; m_cnt = 0;
        end else begin
            case (m_st)
                S_IDLE:    begin m_st = S_CLOSED; m_cnt = 0; end
                S_CLOSED:  if (trig || m_cnt == CLOSED_FRAMES - 1) m_st = S_OPENING; else m_cnt++;
                S_OPENING: begin
                    m_y = (m_y - STEP > OPEN_Y) ? m_y - STEP : OPEN_Y;
                    if (m_y == OPEN_Y) begin m_st = S_OPEN; m_cnt = 0; end
                end
                S_OPEN:    if (m_cnt == OPEN_FRAMES - 1) m_st = S_CLOSING; else m_cnt++;
                S_CLOSING: begin
                    if (col) m_st = S_OPENING;
                    else begin
                        m_y = (m_y + STEP < CLOSED_Y) ? m_y + STEP : CLOSED_Y;
                        if (m_y == CLOSED_Y) begin m_st = S_CLOSED; m_cnt = 0; end
                    end
                end
                default: ;
            endcase
        end
        m_warn = (m_st == S_OPEN) && (m_cnt >= OPEN_FRAMES - WARN_FRAMES);
        m_warn_run = (m_warn && was_warn) ? m_warn_run + 1 : 0;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.y = m_y; e.st = m_st; e.open = (m_st == S_OPEN) ? 1 : 0; e.warn = m_warn ? 1 : 0;
`ifdef GATE_A_BLINK_EN
        e.vis = (!m_warn || ((m_warn_run / 8) % 2 == 0)) ? 1 : 0;
`else
        e.vis = 1;
`endif
        return e;
    endfunction

    task automatic do_frame(input int en_pct, input int trig_pct, input int col_pct);
        bit en, tr, co;
        en = ($urandom_range(99) < 32'(en_pct));
        tr = ($urandom_range(99) < 32'(trig_pct));
        co = ($urandom_range(99) < 32'(col_pct));
        @(negedge CLK);
        enable = en; trigger = tr; collision = co; startOfFrame = 1'b1;
        model_frame(en, tr, co);
        exp_q.push_back(model_exp());
        @(negedge CLK);
        startOfFrame = 1'b0;
        // Inputs between pulses must be ignored, so scramble them.
        enable    = 1'($urandom_range(1));
        trigger   = 1'($urandom_range(1));
        collision = 1'($urandom_range(1));
        repeat ($urandom_range(1, 3)) @(negedge CLK);
    endtask

    always @(posedge CLK) sof_seen <= startOfFrame;

    // Monitor: pops on every cycle that follows a frame pulse, otherwise checks hold.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (sof_seen) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard_empty actual=0 expected=1 entry");
                    end else begin
                        last_exp = exp_q.pop_front();
                        check_all(last_exp, "frame");
                    end
                end else begin
                    check_all(last_exp, "hold");
                end
            end
        end
    end

    initial begin
        bit found;
        model_reset();
        last_exp = reset_exp();
        #1 RESETn = 1'b0;
        #2 check_all(reset_exp(), "reset_async");
        repeat (3) @(negedge CLK);
        check_all(reset_exp(), "reset_held");
        #2 RESETn = 1'b1;
        mon_en = 1'b1;

        // Undisturbed run through full closed/open/close cycles.
        for (int i = 0; i < 240; i++) do_frame(100, 0, 0);
        for (int i = 0; i < 600; i++) do_frame(99, 4, 20);

        // Async reset while sliding.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            do_frame(100, 100, 0);
            found = (m_st == S_OPENING) && (m_y < CLOSED_Y);
        end
        check("slide_reached", 32'(found), 32'd1);
        mon_en = 1'b0;
        #2 RESETn = 1'b0;
        #1 check_all(reset_exp(), "reset_midslide");
        model_reset();
        last_exp = reset_exp();
        @(negedge CLK);
        #2 RESETn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 400; i++) do_frame(95, 10, 30);

        repeat (3) @(negedge CLK);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
